mic_sampler: RTL and testbench

Front-end capture stage that sits directly upstream of the audio delay line. It takes the raw per-clock microphone sample and box-car averages 2^shift consecutive samples into one decimated sample. It emits that sample with a one-cycle strobe, which drives the delay line's `mic_signal` input and its `wr`/`rd` enables. It also counts emitted samples and flags when the delay RAM holds a full window, so delayed output is meaningful from then on.

---
 rtl/mic_pkg.sv | 24 ++
 rtl/mic_sampler_window_accumulator.sv | 69 ++++++
 rtl/mic_sampler.sv | 119 +++++++++++
 tb/tb_mic_sampler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// ---------------------------------------------------------------------------
// mic_pkg
// Shared types and constants for the microphone capture front end.
//   mic_state_t : capture FSM state (IDLE, ACCUM)
//   SHIFT_MAX   : largest averaging exponent; also the sample-counter width
//   ACC_EXTRA   : accumulator growth bits above the sample width
//   win_last()  : last sample index (N-1) of a window for a given exponent
// ---------------------------------------------------------------------------
package mic_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } mic_state_t;

  localparam int SHIFT_MAX = 3;
  localparam int ACC_EXTRA = 3;

  // N-1 for N = 2^s. With s <= 3 this fits the 3-bit window counter.
  function automatic logic [SHIFT_MAX-1:0] win_last(input logic [1:0] s);
    return SHIFT_MAX'((1 << s) - 1);
  endfunction

endpackage

// File: rtl/mic_sampler_window_accumulator.sv
// ---------------------------------------------------------------------------
// window_accumulator
// Box-car accumulator for one averaging window of 2^shift_q samples.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : drop any partial window (idle or aborting)
//   add          : sample is valid and belongs to the current window
//   sample       : incoming sample (unsigned)
//   shift_q      : averaging exponent in force for this window
//   window_done  : this sample completes the window
//   result       : (acc + sample) >> shift_q, valid with window_done
//   clip_acc     : window so far (including this sample) touched 0 or full scale
// ---------------------------------------------------------------------------
module window_accumulator
  import mic_pkg::*;
#(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               add,
  input  logic [D_WIDTH-1:0] sample,
  input  logic [1:0]         shift_q,
  output logic               window_done,
  output logic [D_WIDTH-1:0] result,
  output logic               clip_acc
);

  // Eight full-scale samples need exactly ACC_EXTRA more bits; no wrap possible.
  localparam int ACC_W = D_WIDTH + ACC_EXTRA;

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [SHIFT_MAX-1:0] cnt;
  logic                 clip_q;
  logic                 sample_clip;

  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    sample_clip = (sample == '0) || (sample == '1);
    acc_sum     = acc + ACC_W'(sample);
    window_done = add && (cnt == win_last(shift_q));
    clip_acc    = clip_q || (add && sample_clip);
    // Floor average; the sum of 2^shift_q samples shifted back always fits D_WIDTH.
    result      = D_WIDTH'(acc_sum >> shift_q);
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc    <= '0;
      cnt    <= '0;
      clip_q <= 1'b0;
    end else if (add) begin
      if (window_done) begin
        // Next window starts on the very next accepted sample, no gap cycle.
        acc    <= '0;
        cnt    <= '0;
        clip_q <= 1'b0;
      end else begin
        acc    <= acc_sum;
        cnt    <= cnt + 1'b1;
        clip_q <= clip_acc;
      end
    end
  end

endmodule

// File: rtl/mic_sampler.sv
// ---------------------------------------------------------------------------
// mic_sampler
// Decimating capture stage ahead of the audio delay line: averages 2^shift
// raw samples into one output sample with a one-cycle strobe, and tracks how
// many samples have been written into the 2^A_WIDTH-deep delay RAM.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : capture enable; low aborts to idle and discards the window
//   shift         : averaging exponent (N = 1, 2, 4, 8), taken at window start
//   mic_in        : raw unsigned sample, valid every cycle
//   sample_out    : averaged sample, held between strobes
//   sample_valid  : one-cycle strobe marking a new sample_out
//   clip          : window contained 0 or full scale; reads 0 off-strobe
//   buffer_full   : sticky once 2^A_WIDTH samples emitted since capture start
// ---------------------------------------------------------------------------
module mic_sampler
  import mic_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         shift,
  input  logic [D_WIDTH-1:0] mic_in,
  output logic [D_WIDTH-1:0] sample_out,
  output logic               sample_valid,
  output logic               clip,
  output logic               buffer_full
);

  localparam int FILL_W = A_WIDTH + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = {1'b1, {A_WIDTH{1'b0}}};

  mic_state_t         state;
  logic [1:0]         shift_q;
  logic [D_WIDTH-1:0] mic_q;
  logic               take_q;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;

  logic               acc_clear;
  logic               window_done;
  logic [D_WIDTH-1:0] avg;
  logic               clip_win;

  // Samples are registered at the edge they are accepted and folded into the
  // window one cycle later, so the strobe lands one cycle after the last
  // accepted sample of its window.
  assign acc_clear = (state == IDLE) || !en;

  window_accumulator #(
    .D_WIDTH (D_WIDTH)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .add         (take_q),
    .sample      (mic_q),
    .shift_q     (shift_q),
    .window_done (window_done),
    .result      (avg),
    .clip_acc    (clip_win)
  );

  always_comb begin
    fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shift_q      <= '0;
      mic_q        <= '0;
      take_q       <= 1'b0;
      fill         <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
      buffer_full  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      clip         <= 1'b0;
      mic_q        <= mic_in;
      take_q       <= (state == ACCUM) && en;

      // A completing window is emitted even if en drops on this same edge.
      if (window_done) begin
        sample_out   <= avg;
        sample_valid <= 1'b1;
        clip         <= clip_win;
        shift_q      <= shift;
      end

      unique case (state)
        IDLE: begin
          fill        <= '0;
          buffer_full <= 1'b0;
          shift_q     <= en ? shift : 2'd0;
          if (en) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (!en) begin
            state       <= IDLE;
            fill        <= '0;
            buffer_full <= 1'b0;
          end else if (window_done) begin
            fill        <= fill_next;
            buffer_full <= (fill_next == FILL_MAX);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_sampler.sv
// ---------------------------------------------------------------------------
// tb_mic_sampler
// Self-checking bench for mic_sampler. A queue-based reference model groups
// accepted samples into windows and predicts every output after each edge.
// ---------------------------------------------------------------------------
module tb_mic_sampler;

  localparam int D_WIDTH  = 8;
  localparam int A_WIDTH  = 9;
  localparam int FULL_CNT = 1 << A_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   shift;
  logic [7:0]   mic_in;
  logic [7:0]   sample_out;
  logic         sample_valid;
  logic         clip;
  logic         buffer_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mic_sampler #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .shift        (shift),
    .mic_in       (mic_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .clip         (clip),
    .buffer_full  (buffer_full)
  );

  // ---------------- reference model ----------------
  bit m_active;
  int m_n;
  int win[$];
  bit m_pend;
  int m_pend_out;
  bit m_pend_clip;
  int m_out;
  bit m_valid;
  bit m_clip;
  bit m_full;
  int m_fill;

  // Called at each rising edge with the inputs the DUT sees at that edge.
  function automatic void model_edge();
    int sum;
    bit any_clip;
    if (rst) begin
      m_active = 0; win.delete(); m_pend = 0;
      m_out = 0; m_valid = 0; m_clip = 0; m_full = 0; m_fill = 0;
      return;
    end
    m_valid = 0;
    m_clip  = 0;
    if (m_pend) begin
      m_valid = 1;
      m_out   = m_pend_out;
      m_clip  = m_pend_clip;
      m_fill  = (m_fill < FULL_CNT) ? m_fill + 1 : FULL_CNT;
      m_full  = (m_fill == FULL_CNT);
      m_pend  = 0;
      m_n     = 1 << shift;
    end
    if (!m_active) begin
      m_fill = 0; m_full = 0;
      if (en) begin
        m_active = 1;
        m_n = 1 << shift;
        win.delete();
      end
    end else if (!en) begin
      m_active = 0; win.delete(); m_fill = 0; m_full = 0;
    end else begin
      win.push_back(int'(mic_in));
      if (win.size() == m_n) begin
        sum = 0; any_clip = 0;
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] == 0 || win[i] == 255) any_clip = 1;
        end
        m_pend      = 1;
        m_pend_out  = sum / m_n;
        m_pend_clip = any_clip;
        win.delete();
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mic_in = 8'h80;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_sample();
    if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    return 8'($urandom);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int edges;
    rst = 1'b1; en = 1'b1; mic_in = 8'hFF; shift = 2'd2;
    repeat (3) tick();
    checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL reset_sample_out got %0h want 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", sample_valid); end
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip got %0b want 0", clip); end
    checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", buffer_full); end
    rst = 1'b0;
    edges = 0;
    for (int i = 1; i <= 20 && edges == 0; i++) begin
      tick();
      if (sample_valid === 1'b1) edges = i;
    end
    checks++; if (edges != 6) begin errors++; $display("FAIL reset_first_strobe got edge %0d want 6", edges); end
    checks++; if (sample_out !== 8'hFF || clip !== 1'b1) begin
      errors++; $display("FAIL reset_first_value got %0h/%0b want ff/1", sample_out, clip);
    end
  endtask

  task automatic test_average();
    int vals[4] = '{10, 20, 30, 41};
    int gap;
    do_reset();
    shift = 2'd2; en = 1'b1; mic_in = 8'd0;
    tick();
    foreach (vals[i]) begin
      mic_in = 8'(vals[i]);
      tick();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL avg_no_early_strobe idx %0d got %0b want 0", i, sample_valid); end
    end
    mic_in = 8'd100;
    tick();
    checks++; if (sample_valid !== 1'b1 || sample_out !== 8'd25 || clip !== 1'b0) begin
      errors++; $display("FAIL avg_value got v=%0b out=%0d clip=%0b want v=1 out=25 clip=0", sample_valid, sample_out, clip);
    end
    gap = 0;
    for (int i = 1; i <= 10 && gap == 0; i++) begin
      tick();
      if (i == 1) begin
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL avg_one_cycle_strobe got %0b want 0", sample_valid); end
      end
      if (sample_valid === 1'b1) gap = i;
    end
    checks++; if (gap != 4) begin errors++; $display("FAIL avg_period got %0d want 4", gap); end
    checks++; if (sample_out !== 8'd100) begin errors++; $display("FAIL avg_second_value got %0d want 100", sample_out); end
  endtask

  task automatic test_passthrough();
    logic [7:0] prev;
    bit exp_clip;
    do_reset();
    shift = 2'd0; en = 1'b1;
    tick();
    mic_in = 8'd0;
    tick();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL pass_first got %0b want 0", sample_valid); end
    for (int v = 1; v <= 256; v++) begin
      prev = 8'(v - 1);
      exp_clip = (prev == 8'd0) || (prev == 8'd255);
      mic_in = 8'(v);
      tick();
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== prev || clip !== exp_clip) begin
        errors++;
        $display("FAIL pass_ramp got v=%0b out=%0d clip=%0b want v=1 out=%0d clip=%0b",
                 sample_valid, sample_out, clip, prev, exp_clip);
      end
    end
  endtask

  task automatic test_fullscale();
    do_reset();
    shift = 2'd3; en = 1'b1;
    tick();
    mic_in = 8'hFF;
    repeat (8) tick();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL full_scale_early got %0b want 0", sample_valid); end
    mic_in = 8'h80;
    tick();
    checks++; if (sample_valid !== 1'b1 || sample_out !== 8'hFF || clip !== 1'b1) begin
      errors++; $display("FAIL full_scale got v=%0b out=%0h clip=%0b want 1/ff/1", sample_valid, sample_out, clip);
    end
  endtask

  task automatic test_abort_and_fill();
    int strobes;
    int seen;
    do_reset();
    shift = 2'd2; en = 1'b1;
    tick();
    strobes = 0;
    // 150 complete windows, then two samples of a partial one.
    for (int i = 0; i < 602; i++) begin
      mic_in = rand_sample();
      tick();
      if (sample_valid === 1'b1) strobes++;
    end
    checks++; if (strobes != 150) begin errors++; $display("FAIL abort_pre_strobes got %0d want 150", strobes); end
    en = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if (sample_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_partial_strobe got %0d want 0", seen); end
    checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL abort_full got %0b want 0", buffer_full); end
    // Refill from zero at one strobe per cycle.
    shift = 2'd0; en = 1'b1;
    tick();
    strobes = 0;
    for (int i = 0; i < 700 && strobes < FULL_CNT + 8; i++) begin
      mic_in = rand_sample();
      tick();
      if (sample_valid === 1'b1) begin
        strobes++;
        checks++;
        if (buffer_full !== (strobes >= FULL_CNT)) begin
          errors++;
          $display("FAIL fill_flag at strobe %0d got %0b want %0b", strobes, buffer_full, strobes >= FULL_CNT);
        end
      end
    end
    checks++; if (strobes != FULL_CNT + 8) begin errors++; $display("FAIL fill_strobes got %0d want %0d", strobes, FULL_CNT + 8); end
  endtask

  task automatic test_shift_change();
    int gaps[3];
    int last;
    int t;
    bit seen;
    do_reset();
    shift = 2'd1; en = 1'b1; mic_in = 8'd50;
    tick();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (sample_valid === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL shift_first_strobe got none want strobe"); end
    // First sample of the next window is already accepted: this is mid-window.
    shift = 2'd3;
    last = 0; t = 0;
    gaps = '{0, 0, 0};
    for (int k = 0; k < 3; k++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick(); t++;
        if (sample_valid === 1'b1) begin
          seen = 1; gaps[k] = t - last; last = t;
        end
      end
    end
    checks++; if (gaps[0] != 2) begin errors++; $display("FAIL shift_old_window got %0d want 2", gaps[0]); end
    checks++; if (gaps[1] != 8 || gaps[2] != 8) begin errors++; $display("FAIL shift_new_window got %0d,%0d want 8,8", gaps[1], gaps[2]); end
    checks++; if (sample_out !== 8'd50) begin errors++; $display("FAIL shift_value got %0d want 50", sample_out); end
  endtask

  task automatic test_random();
    do_reset();
    shift = 2'($urandom_range(0, 3));
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (en) en = ($urandom_range(0, 59) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) shift = 2'($urandom_range(0, 3));
      mic_in = rand_sample();
      tick();
      checks++;
      if (sample_valid !== m_valid || sample_out !== 8'(m_out) || clip !== m_clip || buffer_full !== m_full) begin
        errors++;
        $display("FAIL random cyc %0d got v=%0b out=%0d clip=%0b full=%0b want v=%0b out=%0d clip=%0b full=%0b",
                 i, sample_valid, sample_out, clip, buffer_full, m_valid, m_out, m_clip, m_full);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; shift = 2'd0; mic_in = 8'd0;
    test_reset();
    test_average();
    test_passthrough();
    test_fullscale();
    test_abort_and_fill();
    test_shift_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
